// File: rtl/icap_pkg.sv
// Shared types and helpers for the ICAP stream writer.
package icap_pkg;

  localparam int ICAP_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GNT,
    WRITE,
    DRAIN,
    RELEASE
  } state_t;

  // Reverse the bit order inside each byte (ICAP configuration bit order).
  function automatic logic [ICAP_W-1:0] bitswap32(input logic [ICAP_W-1:0] d);
    logic [ICAP_W-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*k+j] = d[8*k+7-j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_stream_writer.sv
// Arbiter client that streams AXI-Stream bitstream words into a shared ICAP,
// releasing the port only at bitstream boundaries or before the first word.
module icap_stream_writer
  import icap_pkg::*;
#(
  parameter bit          BIT_SWAP    = 1'b1,
  parameter int unsigned REQ_HOLDOFF = 2
) (
  input  logic              icap_clk,
  input  logic              icap_reset,
  input  logic [ICAP_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              cap_req,
  input  logic              cap_gnt,
  input  logic              cap_rel,
  output logic              icap_csib,
  output logic              icap_rdwrb,
  output logic [ICAP_W-1:0] icap_i,
  input  logic              icap_avail,
  input  logic              icap_prerror,
  output logic              busy,
  output logic              done_pulse,
  output logic              err_sticky
);

  localparam logic [3:0] HOLDOFF_INIT = 4'(REQ_HOLDOFF);

  state_t            state;
  logic [3:0]        holdoff;
  logic              avail_q;
  logic              accept;
  logic [ICAP_W-1:0] wdata;

  // tready only depends on registered state, so it never forms a loop with tvalid.
  assign s_axis_tready = ((state == WRITE) && avail_q) || (state == DRAIN);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign wdata         = BIT_SWAP ? bitswap32(s_axis_tdata) : s_axis_tdata;

  always_ff @(posedge icap_clk) begin
    if (icap_reset) begin
      state      <= IDLE;
      holdoff    <= '0;
      avail_q    <= 1'b0;
      cap_req    <= 1'b0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      avail_q    <= icap_avail && !icap_prerror;
      done_pulse <= 1'b0;
      icap_csib  <= 1'b1;
      case (state)
        IDLE: begin
          if (holdoff != 4'd0) holdoff <= holdoff - 4'd1;
          if (s_axis_tvalid && (holdoff <= 4'd1)) begin
            state   <= REQ;
            cap_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          if (cap_gnt) begin
            state      <= GNT;
            icap_rdwrb <= 1'b0;
          end
        end
        GNT: begin
          if (cap_rel || !cap_gnt) state <= RELEASE;
          else if (icap_avail) state <= WRITE;
        end
        WRITE: begin
          // A lost grant or ICAP error abandons the rest of this bitstream.
          if (!cap_gnt || icap_prerror) begin
            err_sticky <= 1'b1;
            state      <= (accept && s_axis_tlast) ? RELEASE : DRAIN;
          end else if (accept) begin
            icap_i    <= wdata;
            icap_csib <= 1'b0;
            if (s_axis_tlast) begin
              done_pulse <= 1'b1;
              state      <= RELEASE;
            end
          end
        end
        DRAIN: begin
          if (accept && s_axis_tlast) state <= RELEASE;
        end
        RELEASE: begin
          cap_req    <= 1'b0;
          icap_rdwrb <= 1'b1;
          if (!cap_gnt && !cap_req) begin
            state   <= IDLE;
            busy    <= 1'b0;
            holdoff <= HOLDOFF_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
